// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the PC, issues word-indexed reads to instruction memory over a
// req/gnt/rvalid handshake, and buffers returned words with their PCs in a
// DEPTH-entry reservation queue. Slots are reserved at grant time, so the
// queue cannot overflow. A redirect flushes the queue, restarts fetch and
// discards the responses of requests that were already granted.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   redirect, redirect_pc     flush and restart fetch at redirect_pc
//   imem_req, imem_addr       read request and word address (= pc)
//   imem_gnt                  request accepted this cycle
//   imem_rvalid, imem_rdata   in-order read response
//   inst_valid, inst, inst_pc head of the queue towards the decoder
//   inst_ready                decoder accepts the head this cycle
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [31:0]    pc;
    logic [PW-1:0]  alloc_ptr;
    logic [PW-1:0]  fill_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  discard;
    logic [DEPTH-1:0] ent_filled;
    logic [31:0]    ent_pc   [DEPTH];
    logic [31:0]    ent_data [DEPTH];

    logic [IW-1:0]  alloc_idx;
    logic [IW-1:0]  fill_idx;
    logic [IW-1:0]  rd_idx;
    logic [PW-1:0]  in_use;
    logic [PW-1:0]  pending;
    logic [PW-1:0]  redirect_discard;
    logic           gnt_fire;
    logic           rsp_drop;
    logic           rsp_fill;
    logic           pop;

    assign alloc_idx = alloc_ptr[IW-1:0];
    assign fill_idx  = fill_ptr[IW-1:0];
    assign rd_idx    = rd_ptr[IW-1:0];

    // Slots reserved but not yet popped, and live requests not yet answered.
    assign in_use  = alloc_ptr - rd_ptr;
    assign pending = alloc_ptr - fill_ptr;

    // Stale (discarded) requests still occupy memory bandwidth credit.
    assign imem_req  = rstn && (in_use < PW'(DEPTH)) && ((pending + discard) < PW'(DEPTH));
    assign imem_addr = pc;

    assign gnt_fire = imem_req && imem_gnt;
    assign rsp_drop = imem_rvalid && (discard != '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fill = imem_rvalid && (discard == '0) && (pending != '0);

    // Everything granted up to and including this cycle, minus this cycle's
    // response, is still owed by memory and must be thrown away.
    assign redirect_discard = pending + discard + PW'(gnt_fire) - PW'(rsp_drop || rsp_fill);

    assign inst_valid = ent_filled[rd_idx] && (rd_ptr != fill_ptr);
    assign inst       = ent_data[rd_idx];
    assign inst_pc    = ent_pc[rd_idx];
    assign pop        = inst_valid && inst_ready;

    // Pointer, queue and PC update; redirect overrides everything else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= RESET_PC;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            discard    <= '0;
            ent_filled <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pc[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else if (redirect) begin
            pc         <= redirect_pc;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            discard    <= redirect_discard;
            ent_filled <= '0;
        end else begin
            if (gnt_fire) begin
                ent_pc[alloc_idx]     <= pc;
                ent_filled[alloc_idx] <= 1'b0;
                alloc_ptr             <= alloc_ptr + PW'(1);
                pc                    <= pc + 32'd1;
            end
            if (rsp_drop) begin
                discard <= discard - PW'(1);
            end
            if (rsp_fill) begin
                ent_data[fill_idx]   <= imem_rdata;
                ent_filled[fill_idx] <= 1'b1;
                fill_ptr             <= fill_ptr + PW'(1);
            end
            if (pop) begin
                ent_filled[rd_idx] <= 1'b0;
                rd_ptr             <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A behavioural memory
// (in-order response queue with per-request latency) serves the DUT; the
// expected instruction stream is a simple running PC that restarts at each
// redirect target, and every word is mem_word(pc).
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic [31:0] gnt_addr[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_due = -1;
    int peak     = 0;
    int first_gnt = -1;
    int gnt_pct  = 100;
    int lat_min  = 1;
    int lat_var  = 0;
    logic last_fire;
    logic last_rvalid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0100 + a;
    endfunction

    // One clock of memory behaviour plus observation of the handshakes.
    task automatic cycle();
        logic fire;
        int   due;
        imem_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        fire = imem_req && imem_gnt;
        if (fire) begin
            due = cyc + lat_min + int'($urandom_range(lat_var));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_addr, due: due});
            gnt_addr.push_back(imem_addr);
            if (first_gnt < 0) first_gnt = cyc;
        end
        if (mq.size() > peak) peak = mq.size();
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_inst.push_back(inst);
        end
        last_fire   = fire;
        last_rvalid = imem_rvalid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_obs();
        got_pc.delete();
        got_inst.delete();
        gnt_addr.delete();
    endtask

    // Reset core and memory together, then release away from the clock edge.
    task automatic do_reset();
        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        mq.delete();
        clear_obs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        cyc       = 0;
        last_due  = -1;
        peak      = 0;
        first_gnt = -1;
        gnt_pct   = 100;
        lat_min   = 1;
        lat_var   = 0;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        #2 rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_checks++;
        if (inst !== 32'd0 || inst_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_inst: got inst %h pc %h want 0 0", inst, inst_pc);
        end
        rstn = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_fail++; $display("FAIL reset_release_req: got req %b addr %h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        int first_val = -1;
        logic [31:0] exp;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (inst_valid && first_val < 0) first_val = cyc;
            cycle();
        end
        n_checks++;
        if (first_val !== first_gnt + 2) begin
            n_fail++; $display("FAIL stream_latency: first valid cycle %0d want %0d", first_val, first_gnt + 2);
        end
        n_checks++;
        if (got_pc.size() !== 38) begin
            n_fail++; $display("FAIL stream_throughput: got %0d pops want 38", got_pc.size());
        end
        exp = 32'd0;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp || got_inst[i] !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL stream[%0d]: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp, mem_word(exp));
            end
            exp++;
        end
    endtask

    task automatic test_full_stall();
        logic held_ok = 1'b1;
        logic [31:0] exp;
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2 && !(inst_valid === 1'b1 && inst_pc === 32'd0 && inst === 32'h100)) held_ok = 1'b0;
            cycle();
        end
        n_checks++;
        if (held_ok !== 1'b1 || inst_valid !== 1'b1 || inst !== 32'h100 || inst_pc !== 32'd0) begin
            n_fail++; $display("FAIL stall_hold: got valid %b inst %h pc %h held %b want 1 100 0 1", inst_valid, inst, inst_pc, held_ok);
        end
        n_checks++;
        if (gnt_addr.size() !== DEPTH) begin
            n_fail++; $display("FAIL stall_grants: got %0d grants want %0d", gnt_addr.size(), DEPTH);
        end
        for (int i = 0; i < gnt_addr.size(); i++) begin
            n_checks++;
            if (gnt_addr[i] !== 32'(i)) begin
                n_fail++; $display("FAIL stall_gnt_addr[%0d]: got %h want %h", i, gnt_addr[i], 32'(i));
            end
        end
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_low: got %b want 0", imem_req); end
        inst_ready = 1'b1;
        cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
            n_fail++; $display("FAIL stall_req_reassert: got req %b addr %h want 1 4", imem_req, imem_addr);
        end
        for (int i = 0; i < 12; i++) cycle();
        exp = 32'd0;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp || got_inst[i] !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp, mem_word(exp));
            end
            exp++;
        end
    endtask

    task automatic test_latency3();
        logic [31:0] exp;
        do_reset();
        lat_min    = 3;
        inst_ready = 1'b1;
        for (int i = 0; i < 60; i++) cycle();
        n_checks++;
        if (peak > DEPTH || peak < 3) begin
            n_fail++; $display("FAIL lat3_outstanding: peak %0d want 3..%0d", peak, DEPTH);
        end
        n_checks++;
        if (got_pc.size() < 40) begin
            n_fail++; $display("FAIL lat3_rate: got %0d pops want at least 40", got_pc.size());
        end
        exp = 32'd0;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp || got_inst[i] !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL lat3[%0d]: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp, mem_word(exp));
            end
            exp++;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        do_reset();
        lat_min    = 4;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (mq.size() !== 3) begin
            n_fail++; $display("FAIL redir_inflight: got %0d outstanding want 3", mq.size());
        end
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        gnt_pct     = 0;
        cycle();
        redirect = 1'b0;
        gnt_pct  = 100;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++; $display("FAIL redir_next: got valid %b req %b addr %h want 0 1 20", inst_valid, imem_req, imem_addr);
        end
        clear_obs();
        for (int i = 0; i < 30; i++) cycle();
        n_checks++;
        if (got_pc.size() < 10) begin
            n_fail++; $display("FAIL redir_resume: got %0d pops want at least 10", got_pc.size());
        end
        exp = 32'h20;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp || got_inst[i] !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL redir[%0d]: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp, mem_word(exp));
            end
            exp++;
        end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] exp;
        int pops_before;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        pops_before = got_pc.size();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        n_checks++;
        if (last_fire !== 1'b1 || last_rvalid !== 1'b1 || got_pc.size() !== pops_before + 1) begin
            n_fail++; $display("FAIL collide_setup: got grant %b rsp %b pops %0d want 1 1 %0d", last_fire, last_rvalid, got_pc.size(), pops_before + 1);
        end
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL collide_next: got valid %b req %b addr %h want 0 1 40", inst_valid, imem_req, imem_addr);
        end
        clear_obs();
        for (int i = 0; i < 20; i++) cycle();
        n_checks++;
        if (got_pc.size() < 10) begin
            n_fail++; $display("FAIL collide_resume: got %0d pops want at least 10", got_pc.size());
        end
        exp = 32'h40;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp || got_inst[i] !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL collide[%0d]: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp, mem_word(exp));
            end
            exp++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_pc !== 32'd0) begin
            n_fail++; $display("FAIL midreset_async: got valid %b req %b pc %h want 0 0 0", inst_valid, imem_req, inst_pc);
        end
        do_reset();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_fail++; $display("FAIL midreset_release: got req %b addr %h want 1 0", imem_req, imem_addr);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        exp = 32'd0;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp || got_inst[i] !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL midreset[%0d]: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp, mem_word(exp));
            end
            exp++;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] fetch_pc;
        logic [31:0] target;
        int seen_pop = 0;
        int seen_gnt = 0;
        int total    = 0;
        do_reset();
        gnt_pct  = 70;
        lat_min  = 1;
        lat_var  = 3;
        exp_pc   = 32'd0;
        fetch_pc = 32'd0;
        for (int i = 0; i < 500; i++) begin
            inst_ready  = (int'($urandom_range(99)) < 70);
            redirect    = (int'($urandom_range(99)) < 4);
            target      = $urandom;
            redirect_pc = target;
            cycle();
            for (int k = seen_pop; k < got_pc.size(); k++) begin
                n_checks++;
                if (got_pc[k] !== exp_pc || got_inst[k] !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rand_stream[%0d]: got pc %h inst %h want pc %h inst %h", k, got_pc[k], got_inst[k], exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                total++;
            end
            seen_pop = got_pc.size();
            for (int k = seen_gnt; k < gnt_addr.size(); k++) begin
                n_checks++;
                if (gnt_addr[k] !== fetch_pc) begin
                    n_fail++; $display("FAIL rand_gnt_addr[%0d]: got %h want %h", k, gnt_addr[k], fetch_pc);
                end
                fetch_pc++;
            end
            seen_gnt = gnt_addr.size();
            if (redirect) begin
                redirect = 1'b0;
                exp_pc   = target;
                fetch_pc = target;
                n_checks++;
                if (inst_valid !== 1'b0 || imem_addr !== target) begin
                    n_fail++; $display("FAIL rand_redirect: got valid %b addr %h want 0 %h", inst_valid, imem_addr, target);
                end
            end
        end
        n_checks++;
        if (peak > DEPTH || total < 100) begin
            n_fail++; $display("FAIL rand_bounds: peak %0d (max %0d) pops %0d (min 100)", peak, DEPTH, total);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_latency3();
        test_redirect();
        test_redirect_collide();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
